// File: rtl/cond_stage_if.sv
// Bundle between the ALU-side driver and cond_stage: instruction inputs, flag view and registered requests.
// With COND_STATS_EN defined, the bundle also carries the exec/squash statistics counters.
interface cond_stage_if #(
  parameter int CNT_W = 16
);
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("cond_stage_if: CNT_W must be at least 1");
  end

  logic       valid_in;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       stall;
  logic       flush;
  logic       CondEx;
  logic [3:0] Flags;
  logic       valid_out;
  logic       PCSrc_q;
  logic       RegWrite_q;
  logic       MemWrite_q;
  logic       CondEx_q;
`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] squash_cnt;
`endif

  modport master (
    output valid_in, Cond, ALUFlags, FlagW, PCS, RegW, MemW, stall, flush,
    input  CondEx, Flags, valid_out, PCSrc_q, RegWrite_q, MemWrite_q, CondEx_q
`ifdef COND_STATS_EN
    , input exec_cnt, squash_cnt
`endif
  );

  modport slave (
    input  valid_in, Cond, ALUFlags, FlagW, PCS, RegW, MemW, stall, flush,
    output CondEx, Flags, valid_out, PCSrc_q, RegWrite_q, MemWrite_q, CondEx_q
`ifdef COND_STATS_EN
    , output exec_cnt, squash_cnt
`endif
  );
endinterface

// File: rtl/cond_stage.sv
// Condition/flag stage after the ALU: holds NZCV, evaluates the ARM condition field and
// registers the condition-gated write requests. Optional COND_STATS_EN adds exec/squash counters.
module cond_stage #(
  parameter logic [3:0] FLAG_RESET = 4'b0000,
  parameter int         CNT_W      = 16
) (
  input logic        clk,
  input logic        reset,
  cond_stage_if.slave bus
);
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("cond_stage: CNT_W must be at least 1");
  end

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic r;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cf;
      4'b0011: r = ~cf;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cf & ~z;
      4'b1001: r = ~(cf & ~z);
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = ~(~z & (n == v));
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  logic [3:0] flags_p1;
  logic       vld_p1;
  logic       pcs_p1;
  logic       regw_p1;
  logic       memw_p1;
  logic       cex_p1;

  logic cex_p0;
  logic adv_p0;
  logic take_p0;
  logic load_p0;
  logic fwr_p0;

  // Stage p0: condition evaluation against the architectural flags and advance control.
  // A flush clears the output register even while stalled, so the load enable covers both.
  always_comb begin
    cex_p0  = cond_eval(bus.Cond, flags_p1);
    adv_p0  = ~bus.stall;
    take_p0 = bus.valid_in & ~bus.flush;
    load_p0 = adv_p0 | bus.flush;
    fwr_p0  = adv_p0 & take_p0 & cex_p0;
  end

  assign bus.CondEx = cex_p0;
  assign bus.Flags  = flags_p1;

  // Stage p1: flag register, each half written independently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_p1 <= FLAG_RESET;
    end else if (fwr_p0) begin
      if (bus.FlagW[1]) flags_p1[3:2] <= bus.ALUFlags[3:2];
      if (bus.FlagW[0]) flags_p1[1:0] <= bus.ALUFlags[1:0];
    end
  end

  // Stage p1: gated requests handed to the next pipeline stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      pcs_p1  <= 1'b0;
      regw_p1 <= 1'b0;
      memw_p1 <= 1'b0;
      cex_p1  <= 1'b0;
    end else if (load_p0) begin
      vld_p1  <= take_p0;
      pcs_p1  <= take_p0 & cex_p0 & bus.PCS;
      regw_p1 <= take_p0 & cex_p0 & bus.RegW;
      memw_p1 <= take_p0 & cex_p0 & bus.MemW;
      cex_p1  <= take_p0 & cex_p0;
    end
  end

  assign bus.valid_out  = vld_p1;
  assign bus.PCSrc_q    = pcs_p1;
  assign bus.RegWrite_q = regw_p1;
  assign bus.MemWrite_q = memw_p1;
  assign bus.CondEx_q   = cex_p1;

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_cnt_p1;
  logic [CNT_W-1:0] squash_cnt_p1;

  // Stage p1: statistics, free-running and wrapping at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_cnt_p1   <= '0;
      squash_cnt_p1 <= '0;
    end else if (adv_p0 & take_p0) begin
      if (cex_p0) exec_cnt_p1   <= exec_cnt_p1 + 1'b1;
      else        squash_cnt_p1 <= squash_cnt_p1 + 1'b1;
    end
  end

  assign bus.exec_cnt   = exec_cnt_p1;
  assign bus.squash_cnt = squash_cnt_p1;
`endif
endmodule

// File: tb/tb_cond_stage.sv
// Self-checking bench for cond_stage: directed scenarios plus a randomized run against a
// flag/condition reference model; counter checks are compiled in with COND_STATS_EN.
module tb_cond_stage;
  localparam int CW = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  cond_stage_if #(.CNT_W(CW)) bus ();

  cond_stage #(.FLAG_RESET(4'b0000), .CNT_W(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: the flags as four booleans.
  bit m_n, m_z, m_c, m_v;
  int m_exec, m_squash;

  function automatic bit ref_cond(input bit [3:0] cc, input bit n, input bit z, input bit c, input bit v);
    bit base;
    if (cc >= 4'd14) return 1'b1;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return cc[0] ? !base : base;
  endfunction

  function automatic logic [4:0] outs();
    return {bus.valid_out, bus.PCSrc_q, bus.RegWrite_q, bus.MemWrite_q, bus.CondEx_q};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_in = 1'b0; bus.Cond = 4'd0; bus.ALUFlags = 4'd0; bus.FlagW = 2'd0;
    bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    {m_n, m_z, m_c, m_v} = 4'b0000;
    m_exec = 0;
    m_squash = 0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #2;
    n_cmp++;
    if (bus.Flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", bus.Flags); end
    n_cmp++;
    if (outs() !== 5'b0) begin n_fail++; $display("FAIL reset_outs got=%b exp=00000", outs()); end
    @(negedge clk);
    reset = 1'b0;
    bus.Cond = 4'b0000;
    #1;
    n_cmp++;
    if (bus.CondEx !== 1'b0) begin n_fail++; $display("FAIL reset_eq got=%b exp=0", bus.CondEx); end
    bus.Cond = 4'b1110;
    #1;
    n_cmp++;
    if (bus.CondEx !== 1'b1) begin n_fail++; $display("FAIL reset_al got=%b exp=1", bus.CondEx); end
  endtask

  task automatic test_flag_forward();
    do_reset();
    bus.valid_in = 1'b1; bus.Cond = 4'b1110; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0100;
    step();
    bus.Cond = 4'b0000; bus.FlagW = 2'b00; bus.RegW = 1'b1;
    #1;
    n_cmp++;
    if (bus.Flags !== 4'b0100) begin n_fail++; $display("FAIL fwd_flags got=%b exp=0100", bus.Flags); end
    n_cmp++;
    if (bus.CondEx !== 1'b1) begin n_fail++; $display("FAIL fwd_condex got=%b exp=1", bus.CondEx); end
    step();
    n_cmp++;
    if (outs() !== 5'b10101) begin n_fail++; $display("FAIL fwd_regwrite got=%b exp=10101", outs()); end
  endtask

  task automatic test_half_write();
    do_reset();
    bus.valid_in = 1'b1; bus.Cond = 4'b1110; bus.FlagW = 2'b01; bus.ALUFlags = 4'b1111;
    step();
    n_cmp++;
    if (bus.Flags !== 4'b0011) begin n_fail++; $display("FAIL half_flags got=%b exp=0011", bus.Flags); end
    bus.Cond = 4'b1010; bus.FlagW = 2'b00; bus.MemW = 1'b1;
    #1;
    n_cmp++;
    if (bus.CondEx !== 1'b0) begin n_fail++; $display("FAIL half_ge got=%b exp=0", bus.CondEx); end
    step();
    n_cmp++;
    if (outs() !== 5'b10000) begin n_fail++; $display("FAIL half_memwrite got=%b exp=10000", outs()); end
  endtask

  task automatic test_stall();
    do_reset();
    bus.valid_in = 1'b1; bus.Cond = 4'b1110; bus.RegW = 1'b1;
    step();
    bus.Cond = 4'b0001; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1000; bus.RegW = 1'b0;
    bus.PCS = 1'b1; bus.stall = 1'b1;
    step();
    step();
    n_cmp++;
    if (bus.Flags !== 4'b0000) begin n_fail++; $display("FAIL stall_flags got=%b exp=0000", bus.Flags); end
    n_cmp++;
    if (outs() !== 5'b10101) begin n_fail++; $display("FAIL stall_hold got=%b exp=10101", outs()); end
    n_cmp++;
    if (bus.CondEx !== 1'b1) begin n_fail++; $display("FAIL stall_condex got=%b exp=1", bus.CondEx); end
    bus.stall = 1'b0;
    step();
    n_cmp++;
    if (bus.Flags !== 4'b1000) begin n_fail++; $display("FAIL stall_release_flags got=%b exp=1000", bus.Flags); end
    n_cmp++;
    if (outs() !== 5'b11001) begin n_fail++; $display("FAIL stall_release_outs got=%b exp=11001", outs()); end
  endtask

  task automatic test_stall_flush();
    // Continues from test_stall: Flags=1000 and a valid instruction in the output register.
    bus.Cond = 4'b1110; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0110; bus.PCS = 1'b1;
    bus.stall = 1'b1; bus.flush = 1'b1;
    step();
    n_cmp++;
    if (bus.Flags !== 4'b1000) begin n_fail++; $display("FAIL sf_flags got=%b exp=1000", bus.Flags); end
    n_cmp++;
    if (outs() !== 5'b00000) begin n_fail++; $display("FAIL sf_outs got=%b exp=00000", outs()); end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.valid_in = 1'b1; bus.Cond = 4'b1110; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1010;
    bus.RegW = 1'b1; bus.MemW = 1'b1;
    step();
    bus.stall = 1'b1; bus.flush = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.Flags, outs()} !== 9'b0) begin
      n_fail++; $display("FAIL async_reset got=%b exp=000000000", {bus.Flags, outs()});
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
  endtask

  task automatic test_random();
    bit [3:0] cc, af;
    bit [1:0] fw;
    bit vi, st, fl, pcs, rw, mw, ce, tk;
    logic [4:0] exp_outs;
    do_reset();
    exp_outs = 5'b0;
    for (int i = 0; i < 400; i++) begin
      cc = 4'($urandom_range(0, 15)); af = 4'($urandom_range(0, 15)); fw = 2'($urandom_range(0, 3));
      vi = ($urandom_range(0, 9) < 8); st = ($urandom_range(0, 3) == 0); fl = ($urandom_range(0, 6) == 0);
      pcs = 1'($urandom); rw = 1'($urandom); mw = 1'($urandom);
      bus.Cond = cc; bus.ALUFlags = af; bus.FlagW = fw; bus.valid_in = vi;
      bus.stall = st; bus.flush = fl; bus.PCS = pcs; bus.RegW = rw; bus.MemW = mw;
      #1;
      ce = ref_cond(cc, m_n, m_z, m_c, m_v);
      n_cmp++;
      if ({bus.CondEx, bus.Flags} !== {ce, m_n, m_z, m_c, m_v}) begin
        n_fail++; $display("FAIL rand_comb[%0d] got=%b exp=%b", i, {bus.CondEx, bus.Flags}, {ce, m_n, m_z, m_c, m_v});
      end
      tk = vi && !fl;
      if (fl || !st) exp_outs = {tk, tk && ce && pcs, tk && ce && rw, tk && ce && mw, tk && ce};
      if (!st && tk) begin
        if (ce) begin
          if (fw[1]) {m_n, m_z} = af[3:2];
          if (fw[0]) {m_c, m_v} = af[1:0];
          m_exec = (m_exec + 1) % (1 << CW);
        end else begin
          m_squash = (m_squash + 1) % (1 << CW);
        end
      end
      step();
      n_cmp++;
      if ({outs(), bus.Flags} !== {exp_outs, m_n, m_z, m_c, m_v}) begin
        n_fail++; $display("FAIL rand_reg[%0d] got=%b exp=%b", i, {outs(), bus.Flags}, {exp_outs, m_n, m_z, m_c, m_v});
      end
`ifdef COND_STATS_EN
      n_cmp++;
      if ({bus.exec_cnt, bus.squash_cnt} !== {CW'(m_exec), CW'(m_squash)}) begin
        n_fail++; $display("FAIL rand_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, bus.exec_cnt, bus.squash_cnt, m_exec, m_squash);
      end
`endif
    end
    idle();
  endtask

`ifdef COND_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.valid_in = 1'b1; bus.Cond = 4'b1110;
    for (int i = 0; i < 17; i++) step();
    n_cmp++;
    if (bus.exec_cnt !== CW'(1)) begin n_fail++; $display("FAIL stats_exec_wrap got=%0d exp=1", bus.exec_cnt); end
    bus.Cond = 4'b0000;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (bus.squash_cnt !== CW'(3)) begin n_fail++; $display("FAIL stats_squash got=%0d exp=3", bus.squash_cnt); end
    bus.stall = 1'b1;
    step();
    n_cmp++;
    if ({bus.exec_cnt, bus.squash_cnt} !== {CW'(1), CW'(3)}) begin
      n_fail++; $display("FAIL stats_stall got=%0d/%0d exp=1/3", bus.exec_cnt, bus.squash_cnt);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.exec_cnt, bus.squash_cnt} !== '0) begin
      n_fail++; $display("FAIL stats_async_reset got=%0d/%0d exp=0/0", bus.exec_cnt, bus.squash_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b0;
    idle();
    test_reset();
    test_flag_forward();
    test_half_write();
    test_stall();
    test_stall_flush();
    test_async_reset();
    test_random();
`ifdef COND_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
